// File: rtl/fft_twid_fetch.sv
// Twiddle-set sequencer: walks one radix-4 twiddle sub-table in the ROM, absorbs the
// 1-cycle read latency and hands each packed 6-word set to the butterfly over valid/ready.
module fft_twid_fetch #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BASE0  = 0,
  parameter int unsigned BASE1  = 24,
  parameter int unsigned BASE2  = 120,
  parameter int unsigned WORDS  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                tab_sel,
  input  logic                      abort,
  output logic                      busy,
  output logic                      err,
  output logic                      done,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout,
  output logic                      tw_valid,
  input  logic                      tw_ready,
  output logic [WORDS*DATA_W-1:0]   tw_data,
  output logic [5:0]                tw_idx,
  output logic                      tw_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CAP   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [5:0]                last_q, last_d;   // N-1 of the selected table
  logic [5:0]                j_q, j_d;
  logic [2:0]                w_q, w_d;
  logic [ADDR_W-1:0]         addr_q;
  logic                      cap_en_q;
  logic [2:0]                cap_w_q;
  logic [WORDS*DATA_W-1:0]   data_q;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  logic                      fetching;
  logic                      handshake;
  logic                      at_last;
  logic [ADDR_W-1:0]         fetch_addr;

  assign fetching   = (state_q == S_FETCH);
  assign handshake  = (state_q == S_HOLD) && tw_ready;
  assign at_last    = (j_q == last_q);
  assign fetch_addr = base_q + ADDR_W'(j_q) * ADDR_W'(WORDS) + ADDR_W'(w_q);

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    last_d  = last_q;
    j_d     = j_q;
    w_d     = w_q;
    err_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (tab_sel == 2'd3) begin
            err_d = 1'b1;
          end else begin
            j_d     = '0;
            w_d     = '0;
            state_d = S_FETCH;
            case (tab_sel)
              2'd0:    begin base_d = ADDR_W'(BASE0); last_d = 6'd3;  end
              2'd1:    begin base_d = ADDR_W'(BASE1); last_d = 6'd15; end
              default: begin base_d = ADDR_W'(BASE2); last_d = 6'd63; end
            endcase
          end
        end
      end
      S_FETCH: begin
        if (w_q == 3'(WORDS - 1)) begin
          w_d     = '0;
          state_d = S_CAP;
        end else begin
          w_d = w_q + 3'd1;
        end
      end
      S_CAP: state_d = S_HOLD;
      S_HOLD: begin
        if (tw_ready) begin
          if (at_last) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            j_d     = j_q + 6'd1;
            w_d     = '0;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush wins over a same-cycle handshake or start.
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      last_q   <= '0;
      j_q      <= '0;
      w_q      <= '0;
      addr_q   <= '0;
      cap_en_q <= 1'b0;
      cap_w_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_q   <= last_d;
      j_q      <= j_d;
      w_q      <= w_d;
      err_q    <= err_d;
      done_q   <= done_d;
      if (fetching) addr_q <= fetch_addr;
      // The ROM answers one cycle after the read, so slot tracking trails by a cycle.
      cap_en_q <= fetching && !abort;
      cap_w_q  <= w_q;
    end
  end

  // NOTE: the packed set register is reset explicitly because tw_data has a defined
  // reset value; it is a flop bank, not a RAM, so this costs nothing unusual.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (cap_en_q) begin
      data_q[int'(cap_w_q)*DATA_W +: DATA_W] <= rom_dout;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign done     = done_q;
  assign rom_en   = fetching;
  assign rom_addr = fetching ? fetch_addr : addr_q;
  assign tw_valid = (state_q == S_HOLD);
  assign tw_data  = data_q;
  assign tw_idx   = j_q;
  assign tw_last  = (state_q == S_HOLD) && at_last;

endmodule

// File: tb/tb_fft_twid_fetch.sv
// Self-checking bench for fft_twid_fetch: a ROM model feeds the DUT, a scoreboard queue
// holds expected sets and addresses, and a negedge monitor compares what the DUT presents.
module tb_fft_twid_fetch;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 6;

  typedef struct {
    logic [NW*DW-1:0] data;
    logic [5:0]       idx;
    logic             last;
  } set_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        tab_sel;
  logic              abort;
  logic              busy, err, done, rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_dout;
  logic              tw_valid, tw_ready, tw_last;
  logic [NW*DW-1:0]  tw_data;
  logic [5:0]        tw_idx;

  logic [DW-1:0]     rom [0:503];
  set_t              exp_q[$];
  logic [AW-1:0]     addr_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                hs_count = 0;

  fft_twid_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tab_sel  (tab_sel),
    .abort    (abort),
    .busy     (busy),
    .err      (err),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_data  (tw_data),
    .tw_idx   (tw_idx),
    .tw_last  (tw_last)
  );

  always #5 clk = ~clk;

  // Registered-read ROM model.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= (rom_addr < 10'd504) ? rom[rom_addr] : '0;
  end

  task automatic check(input string name, input logic [NW*DW-1:0] act,
                       input logic [NW*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic load6(input int base, input logic [DW-1:0] w0, w1, w2, w3, w4, w5);
    rom[base]   = w0; rom[base+1] = w1; rom[base+2] = w2;
    rom[base+3] = w3; rom[base+4] = w4; rom[base+5] = w5;
  endtask

  task automatic push_run(input int sel);
    int   base;
    int   n;
    set_t s;
    base = (sel == 0) ? 0 : (sel == 1) ? 24 : 120;
    n    = (sel == 0) ? 4 : (sel == 1) ? 16 : 64;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < NW; k++) begin
        s.data[k*DW +: DW] = rom[base + 6*j + k];
        addr_q.push_back(AW'(base + 6*j + k));
      end
      s.idx  = 6'(j);
      s.last = (j == n - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [1:0] sel);
    tab_sel = sel;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tw_valid === 1'b1) return;
      step();
    end
    fail("tw_valid_timeout");
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        check("busy_at_done", busy, 0);
        return;
      end
      step();
    end
    fail("done_timeout");
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_sets_left"}, exp_q.size(), 0);
    check({tag, "_addrs_left"}, addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_err"},      err,      0);
    check({tag, "_done"},     done,     0);
    check({tag, "_rom_en"},   rom_en,   0);
    check({tag, "_tw_valid"}, tw_valid, 0);
    check({tag, "_tw_last"},  tw_last,  0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_tw_data"},  tw_data,  0);
    check({tag, "_tw_idx"},   tw_idx,   0);
  endtask

  // Monitor: address stream, handshakes, stall stability and the done pulse.
  logic              prev_stall = 1'b0;
  logic [NW*DW-1:0]  prev_data;
  logic [5:0]        prev_idx;
  logic              prev_last;
  logic              done_exp = 1'b0;

  always @(negedge clk) begin
    set_t e;
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      check("done_pulse", done, done_exp);
      done_exp = 1'b0;
      if (rom_en === 1'b1) begin
        if (addr_q.size() == 0) fail("rom_en_unexpected");
        else check("rom_addr", rom_addr, addr_q.pop_front());
      end
      if (prev_stall && tw_valid) begin
        check("stall_data", tw_data, prev_data);
        check("stall_idx",  tw_idx,  prev_idx);
        check("stall_last", tw_last, prev_last);
      end
      if (tw_valid && tw_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          fail("set_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("tw_data", tw_data, e.data);
          check("tw_idx",  tw_idx,  e.idx);
          check("tw_last", tw_last, e.last);
          done_exp = e.last && !abort;
        end
      end
      prev_stall = tw_valid && !tw_ready;
      prev_data  = tw_data;
      prev_idx   = tw_idx;
      prev_last  = tw_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 504; a++) rom[a] = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    load6(6,   32'h5a82799a, 32'hd2bec333, 32'h539eba45, 32'he7821d59, 32'h539eba45, 32'hc4df2862);
    load6(114, 32'hcdb72c7e, 32'hf383a3e2, 32'h45f704f7, 32'hc04ee4b8, 32'hb02d7724, 32'h3d3e82ae);
    load6(120, 32'h40000000, 32'h0,        32'h40000000, 32'h0,        32'h40000000, 32'h0);
    load6(498, 32'hc337a8f7, 32'hfcdc1342, 32'h418d2621, 32'hc004ef3f, 32'hbb771c81, 32'h3fd39b5a);

    rst_n = 1'b0; start = 1'b0; tab_sel = 2'd0; abort = 1'b0; tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_reset_outputs("reset");

    // 4-set table, ready held high, latency to first valid.
    tw_ready = 1'b1;
    push_run(0);
    issue_start(2'd0);
    repeat (6) step();
    check("latency_before", tw_valid, 0);
    step();
    check("latency_first", tw_valid, 1);
    wait_done(100);
    check_drained("tab0");

    // 16-set table with 5 stall cycles on every set.
    tw_ready = 1'b0;
    push_run(1);
    issue_start(2'd1);
    for (int s = 0; s < 16; s++) begin
      wait_valid(50);
      repeat (5) step();
      tw_ready = 1'b1;
      step();
      tw_ready = 1'b0;
    end
    wait_done(50);
    check_drained("tab1");

    // 64-set table, full run.
    tw_ready = 1'b1;
    hs_count = 0;
    push_run(2);
    issue_start(2'd2);
    wait_done(700);
    check("hs_count_64", hs_count, 64);
    check_drained("tab2");

    // Illegal table select.
    issue_start(2'd3);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_rom_en", rom_en, 0);
    step();
    check("err_clear", err, 0);
    check("err_busy_after", busy, 0);

    // Start during FETCH is ignored.
    push_run(0);
    issue_start(2'd0);
    step();
    issue_start(2'd2);
    wait_done(100);
    check_drained("start_in_fetch");

    // Abort in the third FETCH cycle, then a fresh run.
    push_run(0);
    issue_start(2'd0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rom_en", rom_en, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", tw_valid, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (10) step();
    push_run(0);
    issue_start(2'd0);
    wait_done(100);
    check_drained("after_abort");

    // Abort coincident with the final handshake suppresses done.
    tw_ready = 1'b0;
    push_run(0);
    issue_start(2'd0);
    for (int s = 0; s < 3; s++) begin
      wait_valid(50);
      tw_ready = 1'b1;
      step();
      tw_ready = 1'b0;
    end
    wait_valid(50);
    tw_ready = 1'b1;
    abort    = 1'b1;
    step();
    tw_ready = 1'b0;
    abort    = 1'b0;
    check("abort_last_done", done, 0);
    check("abort_last_busy", busy, 0);
    step();
    check("abort_last_done2", done, 0);
    check_drained("abort_last");

    // Asynchronous reset while holding a set of the 64-set table.
    push_run(2);
    issue_start(2'd2);
    wait_valid(50);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    tw_ready = 1'b1;
    push_run(0);
    issue_start(2'd0);
    wait_done(100);
    check_drained("after_reset");

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
